puf_eval_ctrl: RTL and testbench
================================

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_STAGES, default 64, giving the challenge width (one select bit per MUX2to1 stage pair).
REQ-002 The module SHALL have parameter RESP_BITS, default 128, giving the response length in bits.
REQ-003 The module SHALL have parameter VOTES, default 5, giving evaluations per bit; it SHALL be odd and at least 1.
REQ-004 The module SHALL have parameter SETTLE_CYC, default 4, giving race settle and relax time in cycles; it SHALL be at least 1.
REQ-005 The module SHALL have port clk, input, width 1: the single clock.
REQ-006 The module SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-007 The module SHALL have port start, input, width 1: request one response generation.
REQ-008 The module SHALL have port seed, input, width NUM_STAGES: initial challenge, sampled when start is accepted.
REQ-009 The module SHALL have port challenge, output, width NUM_STAGES: select bits driven to the delay-chain multiplexers.
REQ-010 The module SHALL have port launch, output, width 1: race edge driven into both chain inputs.
REQ-011 The module SHALL have port arb_out, input, width 1: the arbiter latch result, already synchronised.
REQ-012 The module SHALL have port busy, output, width 1: high from start acceptance until resp_valid rises.
REQ-013 The module SHALL have port resp_valid, output, width 1: response available.
REQ-014 The module SHALL have port resp_ready, input, width 1: consumer accepts the response.
REQ-015 The module SHALL have port resp, output, width RESP_BITS: the voted response.
REQ-016 The module SHALL have port unstable_cnt, output, width $clog2(RESP_BITS+1): the count of non-unanimous bits.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, LAUNCH, SETTLE, SAMPLE, RELAX and DONE.
REQ-018 In IDLE, start=1 SHALL load challenge<=seed, or all-ones if seed==0, clear resp, set busy and go to LOAD.
REQ-019 LOAD SHALL last 1 cycle, clear the vote counters and go to LAUNCH.
REQ-020 LAUNCH SHALL drive launch=1 for 1 cycle and go to SETTLE.
REQ-021 SETTLE SHALL keep launch=1 for SETTLE_CYC cycles and then go to SAMPLE.
REQ-022 SAMPLE SHALL keep launch=1, add arb_out to ones_cnt, increment eval_cnt, and go to RELAX.
REQ-023 RELAX SHALL drive launch=0 for SETTLE_CYC cycles.
REQ-024 On leaving RELAX, if eval_cnt<VOTES the FSM SHALL go to LAUNCH.
REQ-025 On leaving RELAX with eval_cnt==VOTES, the FSM SHALL write resp[bit_idx] = (ones_cnt > VOTES/2).
REQ-026 On leaving RELAX with eval_cnt==VOTES, the FSM SHALL advance challenge one LFSR step using the TAPS constant (shift left, feedback into bit 0).
REQ-027 On leaving RELAX with eval_cnt==VOTES, the FSM SHALL increment bit_idx and go to LOAD, or go to DONE if bit_idx==RESP_BITS-1.
REQ-028 Each response bit SHALL take 1+VOTES*(2*SETTLE_CYC+2) cycles, which is 51 cycles at the defaults.
REQ-029 Entering DONE SHALL set resp_valid=1 and busy=0 in the same cycle.
REQ-030 resp and resp_valid SHALL stay stable until a cycle with resp_valid&&resp_ready, after which resp_valid=0 next cycle and the FSM returns to IDLE.
REQ-031 start SHALL be ignored outside IDLE, including while resp_valid is high.
REQ-032 resp_ready SHALL be ignored while resp_valid is low.
REQ-033 challenge SHALL be constant from LOAD through the end of RELAX for each bit.
REQ-034 Counters SHALL be sized $clog2(VOTES+1) and $clog2(RESP_BITS), and SHALL NOT wrap within a run.

Reset
REQ-035 On rst=1 at a clock edge, from any state including mid-race, the FSM SHALL go to IDLE.
REQ-036 Reset SHALL set launch=0, busy=0, resp_valid=0, resp=0, challenge=0 and unstable_cnt=0.
REQ-037 Reset SHALL clear all internal counters.
REQ-038 rst SHALL take priority over start and resp_ready.

Configuration
REQ-039 With PUF_STABILITY_EN defined, each bit whose ones_cnt is neither 0 nor VOTES SHALL increment unstable_cnt.
REQ-040 With PUF_STABILITY_EN defined, unstable_cnt SHALL be cleared on start acceptance and SHALL be valid with resp_valid.
REQ-041 Without PUF_STABILITY_EN, unstable_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised.

Structure
REQ-042 Package puf_pkg SHALL hold the FSM state enum, TAPS (64'hD800_0000_0000_0000 for NUM_STAGES=64) and the default parameter constants.
REQ-043 The LFSR SHALL be a separate sub-module puf_lfsr, with load, step, seed and state ports.

Verification
REQ-044 A bench SHALL drive seed=64'h1, start, with arb_out tied 1, and SHALL check resp=all-ones, resp_valid after 6528 cycles, and unstable_cnt=0.
REQ-045 A bench SHALL drive arb_out = 1 on votes 1-3 and 0 on votes 4-5 of every bit, and SHALL check resp=all-ones and unstable_cnt=128 with PUF_STABILITY_EN.
REQ-046 A bench SHALL drive seed=0 and SHALL check that the first challenge equals 64'hFFFF_FFFF_FFFF_FFFF and that the second challenge equals its one-step LFSR successor.
REQ-047 A bench SHALL hold resp_ready=0 for 20 cycles after resp_valid and SHALL check that resp is stable and that a start pulse is ignored; resp_ready=1 SHALL then give IDLE on the next cycle.
REQ-048 A bench SHALL assert rst during the 3rd SETTLE of bit 10 and SHALL check launch=0, busy=0 and resp=0 the next cycle; a new start SHALL then complete normally.
REQ-049 A bench SHALL monitor every evaluation and SHALL check that launch is high for SETTLE_CYC+2 cycles, low for SETTLE_CYC cycles, and that challenge does not change while launch=1.

Source files
------------

// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg -- shared definitions for the arbiter-PUF evaluation controller.
//
// Contents:
//   DEF_*        default values for the controller parameters
//   TAPS         feedback mask of the 64-stage challenge LFSR (x^64+x^63+x^61+x^60)
//   puf_state_e  controller FSM state encoding
//   cnt_width()  counter width helper that never returns zero
//
// Optional feature: defining PUF_STABILITY_EN enables the unstable-bit counter
// in puf_eval_ctrl.
// -----------------------------------------------------------------------------
package puf_pkg;

  localparam int DEF_NUM_STAGES = 64;
  localparam int DEF_RESP_BITS  = 128;
  localparam int DEF_VOTES      = 5;
  localparam int DEF_SETTLE_CYC = 4;

  // Taps are MSB-aligned so narrower chains can use the top bits of the mask.
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LAUNCH = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    RELAX  = 3'd5,
    DONE   = 3'd6
  } puf_state_e;

  // Width needed to index max_val items; at least 1 so a single-entry
  // range still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// -----------------------------------------------------------------------------
// puf_lfsr -- Fibonacci LFSR that generates successive PUF challenges.
//
// Parameters:
//   WIDTH     register width (2..64)
//   TAP_MASK  feedback taps; defaults to the MSB-aligned slice of puf_pkg::TAPS
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset, clears state to zero
//   load   load seed (an all-zero seed is replaced by all-ones)
//   step   advance one step: shift left, XOR of tapped bits into bit 0
//   seed   initial value, sampled when load=1
//   state  current challenge
// -----------------------------------------------------------------------------
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int                WIDTH    = DEF_NUM_STAGES,
  parameter logic [WIDTH-1:0]  TAP_MASK = WIDTH'(TAPS >> (64 - WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  logic feedback;

  assign feedback = ^(state & TAP_MASK);

  // An all-zero state is the LFSR lock-up point, so a zero seed is replaced
  // with all-ones to guarantee a non-degenerate challenge sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? '1 : seed;
    end else if (step) begin
      state <= {state[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// puf_eval_ctrl -- arbiter-PUF evaluation controller.
//
// For each of RESP_BITS response bits the controller applies one challenge,
// fires VOTES races (launch high for SETTLE_CYC+2 cycles, low for SETTLE_CYC
// cycles), majority-votes the arbiter results and then steps the challenge
// LFSR. One bit takes 1 + VOTES*(2*SETTLE_CYC+2) cycles.
//
// Parameters:
//   NUM_STAGES  challenge width, 2..64
//   RESP_BITS   response length
//   VOTES       evaluations per bit, odd and >= 1
//   SETTLE_CYC  race settle / relax time in cycles, >= 1
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   start         request a response (accepted only in IDLE)
//   seed          initial challenge, sampled on start acceptance
//   challenge     select bits to the delay-chain multiplexers
//   launch        race edge into both chain inputs
//   arb_out       synchronised arbiter result
//   busy          high from start acceptance until resp_valid rises
//   resp_valid    response available, held until resp_ready
//   resp_ready    consumer accepts the response
//   resp          voted response
//   unstable_cnt  number of non-unanimous bits (valid with resp_valid)
//
// Build option: define PUF_STABILITY_EN to enable the unstable-bit counter;
// otherwise unstable_cnt is tied to zero.
// -----------------------------------------------------------------------------
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int RESP_BITS  = DEF_RESP_BITS,
  parameter int VOTES      = DEF_VOTES,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_STAGES-1:0]          seed,
  output logic [NUM_STAGES-1:0]          challenge,
  output logic                           launch,
  input  logic                           arb_out,
  output logic                           busy,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [RESP_BITS-1:0]           resp,
  output logic [$clog2(RESP_BITS+1)-1:0] unstable_cnt
);

  localparam int VOTE_W = $clog2(VOTES + 1);
  localparam int IDX_W  = cnt_width(RESP_BITS);
  localparam int CYC_W  = cnt_width(SETTLE_CYC);
  localparam int UNST_W = $clog2(RESP_BITS + 1);

  localparam logic [VOTE_W-1:0] VOTES_C   = VOTE_W'(VOTES);
  localparam logic [VOTE_W-1:0] MAJORITY  = VOTE_W'(VOTES / 2);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(RESP_BITS - 1);

  if (NUM_STAGES < 2 || NUM_STAGES > 64) begin : g_bad_stages
    $error("puf_eval_ctrl: NUM_STAGES must be in 2..64");
  end
  if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
    $error("puf_eval_ctrl: VOTES must be odd and at least 1");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("puf_eval_ctrl: SETTLE_CYC must be at least 1");
  end

  puf_state_e        state;
  puf_state_e        state_next;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [VOTE_W-1:0] eval_cnt;
  logic [VOTE_W-1:0] ones_cnt;
  logic [IDX_W-1:0]  bit_idx;

  logic start_acc;
  logic cyc_last;
  logic last_vote;
  logic last_bit;
  logic bit_done;

  assign start_acc = (state == IDLE) && start;
  assign cyc_last  = (cyc_cnt == CYC_LAST);
  assign last_vote = (eval_cnt == VOTES_C);
  assign last_bit  = (bit_idx == IDX_LAST);
  // Final RELAX cycle of the last vote: the bit is decided and the
  // challenge moves on.
  assign bit_done  = (state == RELAX) && cyc_last && last_vote;

  // ---------------------------------------------------------------------------
  // Challenge generator
  // ---------------------------------------------------------------------------
  puf_lfsr #(
    .WIDTH (NUM_STAGES)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .step  (bit_done),
    .seed  (seed),
    .state (challenge)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for state_next.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = LAUNCH;
      LAUNCH:  state_next = SETTLE;
      SETTLE:  if (cyc_last) state_next = SAMPLE;
      SAMPLE:  state_next = RELAX;
      RELAX: begin
        if (cyc_last) begin
          if (!last_vote)    state_next = LAUNCH;
          else if (last_bit) state_next = DONE;
          else               state_next = LOAD;
        end
      end
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and response register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: resp is a plain flop vector (not a RAM), so it is cleared
      // here along with the control state.
      state    <= IDLE;
      cyc_cnt  <= '0;
      eval_cnt <= '0;
      ones_cnt <= '0;
      bit_idx  <= '0;
      resp     <= '0;
    end else begin
      state <= state_next;

      // Phase timer runs only inside SETTLE and RELAX and is zero elsewhere,
      // so each phase starts counting from zero.
      if ((state == SETTLE || state == RELAX) && !cyc_last) begin
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      end else begin
        cyc_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            resp     <= '0;
            bit_idx  <= '0;
            eval_cnt <= '0;
            ones_cnt <= '0;
          end
        end
        LOAD: begin
          eval_cnt <= '0;
          ones_cnt <= '0;
        end
        SAMPLE: begin
          ones_cnt <= ones_cnt + VOTE_W'(arb_out);
          eval_cnt <= eval_cnt + VOTE_W'(1);
        end
        RELAX: begin
          if (bit_done) begin
            resp[bit_idx] <= (ones_cnt > MAJORITY);
            // Hold at the last index so the counter never wraps in a run.
            if (!last_bit) bit_idx <= bit_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // Decoded from state_next into flops so launch reaches the delay chains
  // glitch-free; a decode glitch would fire a spurious race.
  always_ff @(posedge clk) begin
    if (rst) begin
      launch     <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      launch     <= (state_next == LAUNCH) || (state_next == SETTLE) ||
                    (state_next == SAMPLE);
      busy       <= (state_next != IDLE) && (state_next != DONE);
      resp_valid <= (state_next == DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Unstable-bit counter
  // ---------------------------------------------------------------------------
`ifdef PUF_STABILITY_EN
  logic [UNST_W-1:0] unst_q;

  // A bit is unstable when its votes were not unanimous.
  always_ff @(posedge clk) begin
    if (rst) begin
      unst_q <= '0;
    end else if (start_acc) begin
      unst_q <= '0;
    end else if (bit_done && (ones_cnt != '0) && (ones_cnt != VOTES_C)) begin
      unst_q <= unst_q + UNST_W'(1);
    end
  end

  assign unstable_cnt = unst_q;
`else
  assign unstable_cnt = '0;
`endif

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_eval_ctrl -- self-checking bench for puf_eval_ctrl at default
// parameters. A negedge monitor acts as the arbiter (driving arb_out per
// vote/bit pattern) and checks race timing; a vector table drives full
// response runs whose expected results go through a scoreboard queue.
// Works with or without PUF_STABILITY_EN defined.
// -----------------------------------------------------------------------------
module tb_puf_eval_ctrl;

  localparam int NS      = 64;
  localparam int RB      = 128;
  localparam int VT      = 5;
  localparam int SC      = 4;
  localparam int BIT_CYC = 1 + VT * (2 * SC + 2);   // 51
  localparam int RUN_CYC = RB * BIT_CYC;            // 6528
`ifdef PUF_STABILITY_EN
  localparam int UNST_EN = 1;
`else
  localparam int UNST_EN = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NS-1:0]        seed;
  logic [NS-1:0]        challenge;
  logic                 launch;
  logic                 arb_out = 1'b0;
  logic                 busy;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [RB-1:0]        resp;
  logic [$clog2(RB+1)-1:0] unstable_cnt;

  puf_eval_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .challenge    (challenge),
    .launch       (launch),
    .arb_out      (arb_out),
    .busy         (busy),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp         (resp),
    .unstable_cnt (unstable_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference LFSR: x^64+x^63+x^61+x^60, shift left, feedback into bit 0.
  function automatic logic [63:0] lfsr_next(input logic [63:0] c);
    return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
  endfunction

  // Arbiter behaviour per mode; vote counts from 1 within a bit.
  function automatic logic arb_pattern(input int m, input int vote, input int bit_no);
    case (m)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return vote <= 3;
      3:       return vote <= 2;
      4:       return (bit_no % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Race monitor / arbiter model
  // ---------------------------------------------------------------------------
  int            mode = 0;
  int            eval_no = 0;
  int            high_len = 0;
  int            low_len = 0;
  logic          launch_prev = 1'b0;
  logic          chal_moved = 1'b0;
  logic [NS-1:0] chal_at_launch = '0;

  always @(negedge clk) begin
    if (rst || !busy) begin
      eval_no     = 0;
      high_len    = 0;
      low_len     = 0;
      launch_prev = 1'b0;
      chal_moved  = 1'b0;
    end else begin
      if (launch) begin
        if (!launch_prev) begin
          int vote;
          int bit_no;
          eval_no++;
          vote   = (eval_no - 1) % VT + 1;
          bit_no = (eval_no - 1) / VT;
          // Gap before a race is RELAX, plus the LOAD cycle at a bit boundary.
          if (eval_no > 1) check("relax_len", low_len, (vote > 1) ? SC : SC + 1);
          arb_out        = arb_pattern(mode, vote, bit_no);
          chal_at_launch = challenge;
          chal_moved     = 1'b0;
          high_len       = 0;
        end
        high_len++;
        if (challenge !== chal_at_launch) chal_moved = 1'b1;
      end else begin
        if (launch_prev) begin
          check("launch_high_len", high_len, SC + 2);
          check("challenge_stable_in_race", chal_moved, 1'b0);
          low_len = 0;
        end
        low_len++;
      end
      launch_prev = launch;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0]  seed;
    int           mode;
    logic [127:0] exp_resp;
    int           exp_unst;
    logic         hold;       // hold resp_ready low 20 cycles, pulse start
    logic         ready_hi;   // keep resp_ready high through the run
  } vec_t;

  typedef struct {
    logic [127:0] resp;
    int           unst;
    int           cyc;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  task automatic run_vector(input vec_t v);
    int   n;
    exp_t e;
    mode       = v.mode;
    resp_ready = v.ready_hi;
    seed       = v.seed;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{v.exp_resp, v.exp_unst, RUN_CYC});
    check("busy_on_start", busy, 1'b1);
    check("challenge_load", challenge, (v.seed == '0) ? {64{1'b1}} : v.seed);
    n = 0;
    while (!resp_valid && n < RUN_CYC + 200) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    check("cycles_to_valid", n, e.cyc);
    check("resp_valid", resp_valid, 1'b1);
    check("resp", resp, e.resp);
    check("unstable_cnt", unstable_cnt, e.unst);
    check("busy_at_done", busy, 1'b0);
    if (v.hold) begin
      logic [RB-1:0] held;
      logic          stable;
      held   = resp;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
        start = (i == 5);
        @(posedge clk); #1;
        if (resp !== held || resp_valid !== 1'b1) stable = 1'b0;
      end
      start = 1'b0;
      check("hold_stable", stable, 1'b1);
      check("start_ignored_in_done", busy, 1'b0);
      resp_ready = 1'b1;
    end else if (!v.ready_hi) begin
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("valid_drop_after_accept", resp_valid, 1'b0);
    check("idle_not_busy", busy, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] exp_chal;
    int          n;

    vecs[0] = '{64'h1,                    0, {128{1'b1}}, 0,            1'b1, 1'b0};
    vecs[1] = '{64'hDEAD_BEEF_0123_4567,  1, 128'h0,      0,            1'b0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0001,  2, {128{1'b1}}, UNST_EN * RB, 1'b0, 1'b0};
    vecs[3] = '{64'h5,                    3, 128'h0,      UNST_EN * RB, 1'b0, 1'b0};
    vecs[4] = '{64'hFFFF_0000_1234_ABCD,  4, {64{2'b01}}, 0,            1'b0, 1'b0};

    // Reset, with start and resp_ready asserted to confirm reset priority.
    rst        = 1'b1;
    start      = 1'b0;
    seed       = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start      = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    resp_ready = 1'b0;
    check("rst_launch", launch, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_resp", resp, '0);
    check("rst_challenge", challenge, '0);
    check("rst_unstable", unstable_cnt, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero seed: all-ones challenge, then LFSR successors at bit boundaries.
    mode  = 0;
    seed  = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_chal = {64{1'b1}};
    check("seed0_first_challenge", challenge, exp_chal);
    repeat (BIT_CYC - 1) @(posedge clk);
    #1;
    check("seed0_challenge_held_bit0", challenge, exp_chal);
    @(posedge clk); #1;
    exp_chal = lfsr_next(exp_chal);
    check("seed0_second_challenge", challenge, exp_chal);
    repeat (BIT_CYC) @(posedge clk);
    #1;
    exp_chal = lfsr_next(exp_chal);
    check("seed0_third_challenge", challenge, exp_chal);

    // Reset mid-race: third evaluation of bit 10, inside SETTLE.
    n = 0;
    while (eval_no < 10 * VT + 3 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_bit10_vote3", eval_no, 10 * VT + 3);
    check("midrace_launch_high", launch, 1'b1);
    check("midrace_partial_resp", resp, 128'h3FF);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrace_rst_launch", launch, 1'b0);
    check("midrace_rst_busy", busy, 1'b0);
    check("midrace_rst_resp", resp, '0);
    check("midrace_rst_valid", resp_valid, 1'b0);
    check("midrace_rst_challenge", challenge, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full runs from the table.
    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
